display_port_bridge: RTL

//  Port-I/O bridge from the KCPSM3 CPU to the character display memory (dsp write port).

---
 rtl/display_port_bridge.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/display_port_bridge.sv
// Port-I/O bridge from the KCPSM3 CPU to the character display memory.
// Direct window, cursor stream port with wrap, attribute/fill registers, clear engine.
module display_port_bridge #(
  parameter int COL_BITS = 7,
  parameter int ROW_BITS = 5,
  parameter int NUM_COLS = 80,
  parameter int NUM_ROWS = 30,
  parameter logic [7:0] DEFAULT_ATTR = 8'h0F
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [7:0]                   port_id,
  input  logic                         write_strobe,
  input  logic [7:0]                   out_port,
  output logic [7:0]                   in_port,
  output logic                         mem_en,
  output logic [ROW_BITS+COL_BITS-1:0] mem_addr,
  output logic [15:0]                  mem_data,
  output logic                         busy
);

  localparam logic [COL_BITS-1:0] LAST_COL = COL_BITS'(NUM_COLS - 1);
  localparam logic [ROW_BITS-1:0] LAST_ROW = ROW_BITS'(NUM_ROWS - 1);
  localparam logic [7:0] COL_LIM = 8'(NUM_COLS);
  localparam logic [7:0] ROW_LIM = 8'(NUM_ROWS);

  typedef enum logic {IDLE, CLEAR} state_t;

  state_t state, state_nx;

  logic [ROW_BITS-1:0] row, cur_row, crow, nx_row;
  logic [COL_BITS-1:0] cur_col, ccol, nx_col, dir_col;
  logic [7:0] attr, fill, c_attr, c_fill, rd_data;
  logic mode;
  logic is_reg, col_ok, is_nl, last_cell;
  logic do_dir, do_str, do_clr;

  assign busy    = (state == CLEAR);
  assign is_reg  = (port_id[7:3] == 5'b10000);
  assign dir_col = COL_BITS'(port_id[6:0]);
  assign col_ok  = ({1'b0, port_id[6:0]} < COL_LIM);
  assign is_nl   = mode && (out_port == 8'h0A);

  assign do_dir = write_strobe && !port_id[7] && col_ok && !busy;
  assign do_str = write_strobe && is_reg && (port_id[2:0] == 3'd4) && !busy;
  assign do_clr = write_strobe && is_reg && (port_id[2:0] == 3'd5)
                  && out_port[0] && !busy;

  assign last_cell = (ccol == LAST_COL) && (crow == LAST_ROW);

  // Cursor advance shared by stream characters and newline
  always_comb begin
    nx_col = cur_col + 1'b1;
    nx_row = cur_row;
    if (is_nl || cur_col == LAST_COL) begin
      nx_col = '0;
      nx_row = (cur_row == LAST_ROW) ? '0 : cur_row + 1'b1;
    end
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:  if (do_clr) state_nx = CLEAR;
      CLEAR: if (last_cell) state_nx = IDLE;
    endcase
  end

  always_comb begin
    rd_data = '0;
    case (port_id)
      8'h80:   rd_data = 8'(row);
      8'h81:   rd_data = attr;
      8'h82:   rd_data = 8'(cur_col);
      8'h83:   rd_data = 8'(cur_row);
      8'h85:   rd_data = {7'b0, busy};
      8'h86:   rd_data = fill;
      8'h87:   rd_data = {7'b0, mode};
      default: rd_data = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nx;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mem_en   <= 1'b0;
      mem_addr <= '0;
      mem_data <= '0;
      in_port  <= '0;
      row      <= '0;
      attr     <= DEFAULT_ATTR;
      cur_col  <= '0;
      cur_row  <= '0;
      fill     <= 8'h20;
      mode     <= 1'b0;
      crow     <= '0;
      ccol     <= '0;
      c_attr   <= '0;
      c_fill   <= '0;
    end else begin
      mem_en  <= 1'b0;
      in_port <= rd_data;
      if (write_strobe && is_reg) begin
        case (port_id[2:0])
          3'd0: if (out_port < ROW_LIM) row <= ROW_BITS'(out_port);
          3'd1: attr <= out_port;
          3'd2: if (out_port < COL_LIM) cur_col <= COL_BITS'(out_port);
          3'd3: if (out_port < ROW_LIM) cur_row <= ROW_BITS'(out_port);
          3'd6: fill <= out_port;
          3'd7: mode <= out_port[0];
          default: ;
        endcase
      end
      unique case (1'b1)
        busy: begin
          mem_en   <= 1'b1;
          mem_addr <= {crow, ccol};
          mem_data <= {c_attr, c_fill};
          if (ccol == LAST_COL) begin
            ccol <= '0;
            crow <= (crow == LAST_ROW) ? '0 : crow + 1'b1;
          end else begin
            ccol <= ccol + 1'b1;
          end
          if (last_cell) begin
            cur_col <= '0;
            cur_row <= '0;
          end
        end
        do_clr: begin
          crow   <= '0;
          ccol   <= '0;
          c_attr <= attr;
          c_fill <= fill;
        end
        do_str: begin
          if (!is_nl) begin
            mem_en   <= 1'b1;
            mem_addr <= {cur_row, cur_col};
            mem_data <= {attr, out_port};
          end
          cur_col <= nx_col;
          cur_row <= nx_row;
        end
        do_dir: begin
          mem_en   <= 1'b1;
          mem_addr <= {row, dir_col};
          mem_data <= {attr, out_port};
        end
        default: ;
      endcase
    end
  end

endmodule
